// File: rtl/ann_train_pkg.sv
// Shared types and default sizes for the ANN training control path.
// Command opcodes and scheduler states are used by the top FSM and the op sequencer.
package ann_train_pkg;

    localparam int LAYERS_DEF = 3;
    localparam int N_OUT_DEF  = 10;

    typedef enum logic [1:0] {
        OP_FWD = 2'b00,
        OP_BWD = 2'b01,
        OP_UPD = 2'b10
    } eng_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/op_sequencer.sv
// Walks the per-sample command list: FWD 0..L-2, BWD L-2..0, UPD 0..L-2.
// o_last flags the final UPD command so the FSM knows the sample is finished.
module op_sequencer
    import ann_train_pkg::*;
#(
    parameter int LAYERS = LAYERS_DEF,
    parameter int LYW    = 1
) (
    input  logic           clk,
    input  logic           rst_vals,
    input  logic           i_clear,
    input  logic           i_advance,
    output eng_op_e        o_op,
    output logic [LYW-1:0] o_layer,
    output logic           o_last
);

    localparam logic [LYW-1:0] LMAX = LYW'(LAYERS - 2);

    eng_op_e        r_op;
    logic [LYW-1:0] r_layer;

    // Turnaround points keep the layer index: the deepest FWD is followed by the deepest BWD.
    always_ff @(posedge clk or negedge rst_vals) begin
        if (!rst_vals) begin
            r_op    <= OP_FWD;
            r_layer <= '0;
        end else if (i_clear) begin
            r_op    <= OP_FWD;
            r_layer <= '0;
        end else if (i_advance) begin
            unique case (r_op)
                OP_FWD: begin
                    if (r_layer == LMAX) begin
                        r_op <= OP_BWD;
                    end else begin
                        r_layer <= r_layer + LYW'(1);
                    end
                end
                OP_BWD: begin
                    if (r_layer == '0) begin
                        r_op <= OP_UPD;
                    end else begin
                        r_layer <= r_layer - LYW'(1);
                    end
                end
                OP_UPD: begin
                    if (r_layer == LMAX) begin
                        r_op    <= OP_FWD;
                        r_layer <= '0;
                    end else begin
                        r_layer <= r_layer + LYW'(1);
                    end
                end
                default: begin
                    r_op    <= OP_FWD;
                    r_layer <= '0;
                end
            endcase
        end
    end

    assign o_op    = r_op;
    assign o_layer = r_layer;
    assign o_last  = (r_op == OP_UPD) && (r_layer == LMAX);

endmodule

// File: rtl/training_scheduler.sv
// Per-sample training sequencer: fetches labelled samples, drives the label encoder,
// and issues FWD/BWD/UPD layer commands to the shared engine while counting samples and epochs.
module training_scheduler
    import ann_train_pkg::*;
#(
    parameter int  LAYERS    = LAYERS_DEF,
    parameter int  N_OUT     = N_OUT_DEF,
    parameter int  N_SAMPLES = 1000,
    parameter int  N_EPOCHS  = 4,
    localparam int LW        = $clog2(N_OUT),
    localparam int LYW       = ($clog2(LAYERS - 1) > 1) ? $clog2(LAYERS - 1) : 1,
    localparam int SW        = $clog2(N_SAMPLES + 1),
    localparam int EW        = $clog2(N_EPOCHS + 1)
) (
    input  logic           clk,
    input  logic           rst_vals,
    input  logic           start,
    input  logic           sample_valid,
    input  logic [LW-1:0]  sample_label,
    output logic           sample_ready,
    output logic [LW-1:0]  lbl_value,
    output logic           lbl_clr,
    output logic           eng_start,
    output logic [1:0]     eng_op,
    output logic [LYW-1:0] eng_layer,
    input  logic           eng_done,
    output logic [SW-1:0]  sample_cnt,
    output logic [EW-1:0]  epoch_cnt,
    output logic           busy,
    output logic           done,
    output logic           bad_label
);

    sched_state_e   r_state;
    logic           r_ready;
    logic           r_eng_start;
    logic           r_busy;
    logic           r_done;
    logic           r_bad;
    logic           r_lbl_clr;
    logic [LW-1:0]  r_lbl_value;
    logic [SW-1:0]  r_sample_cnt;
    logic [EW-1:0]  r_epoch_cnt;

    logic           w_accept;
    logic           w_label_ok;
    logic           w_seq_clear;
    logic           w_seq_advance;
    logic           w_last;
    eng_op_e        w_op;
    logic [LYW-1:0] w_layer;
    logic           w_epoch_wrap;
    logic           w_run_end;

    // One extra bit so a power-of-two N_OUT still compares correctly.
    assign w_label_ok    = {1'b0, sample_label} < (LW + 1)'(N_OUT);
    assign w_accept      = (r_state == S_FETCH) && sample_valid;
    assign w_seq_clear   = w_accept && w_label_ok;
    assign w_seq_advance = (r_state == S_WAIT) && eng_done;
    assign w_epoch_wrap  = (r_sample_cnt == SW'(N_SAMPLES - 1));
    assign w_run_end     = w_epoch_wrap && (r_epoch_cnt == EW'(N_EPOCHS - 1));

    op_sequencer #(
        .LAYERS (LAYERS),
        .LYW    (LYW)
    ) u_op_sequencer (
        .clk       (clk),
        .rst_vals  (rst_vals),
        .i_clear   (w_seq_clear),
        .i_advance (w_seq_advance),
        .o_op      (w_op),
        .o_layer   (w_layer),
        .o_last    (w_last)
    );

    // Outputs are registered alongside each transition so they track the state they belong to.
    always_ff @(posedge clk or negedge rst_vals) begin
        if (!rst_vals) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_eng_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bad        <= 1'b0;
            r_lbl_clr    <= 1'b1;
            r_lbl_value  <= '0;
            r_sample_cnt <= '0;
            r_epoch_cnt  <= '0;
        end else begin
            r_eng_start <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sample_cnt <= '0;
                        r_epoch_cnt  <= '0;
                        r_bad        <= 1'b0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (sample_valid) begin
                        r_lbl_value <= sample_label;
                        r_ready     <= 1'b0;
                        if (w_label_ok) begin
                            r_lbl_clr   <= 1'b0;
                            r_eng_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_bad     <= 1'b1;
                            r_lbl_clr <= 1'b1;
                            r_state   <= S_NEXT;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        if (w_last) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_eng_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_NEXT: begin
                    r_lbl_clr <= 1'b1;
                    if (w_epoch_wrap) begin
                        r_sample_cnt <= '0;
                        r_epoch_cnt  <= r_epoch_cnt + EW'(1);
                    end else begin
                        r_sample_cnt <= r_sample_cnt + SW'(1);
                    end
                    if (w_run_end) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sample_ready = r_ready;
    assign lbl_value    = r_lbl_value;
    assign lbl_clr      = r_lbl_clr;
    assign eng_start    = r_eng_start;
    assign eng_op       = w_op;
    assign eng_layer    = w_layer;
    assign sample_cnt   = r_sample_cnt;
    assign epoch_cnt    = r_epoch_cnt;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bad_label    = r_bad;

endmodule
